// File: rtl/dsp_route_pkg.sv
// dsp_route_pkg: register map, field positions
// and sizing helpers for the route/mix block.
package dsp_route_pkg;

  localparam logic [15:0] SINK_BASE    = 16'h000;
  localparam logic [15:0] SRC_BASE     = 16'h100;
  localparam logic [15:0] COMMIT       = 16'h200;
  localparam logic [15:0] SAT_FLAGS    = 16'h204;
  localparam logic [15:0] SAT_CNT_BASE = 16'h208;

  localparam int SHIFT_LSB = 8;
  localparam int SHIFT_W   = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sel_none(input int n_src);
    return n_src;
  endfunction

endpackage

// File: rtl/dsp_adder_tree.sv
// dsp_adder_tree: pipelined binary adder tree,
// one adder level per clock, odd nodes padded with 0.
module dsp_adder_tree
  import dsp_route_pkg::*;
#(
  parameter int W = 18,
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N*W-1:0] terms_i,
  output logic [W-1:0]   sum_o
);

  localparam int L = clog2(N);
  localparam int P = 1 << L;

  for (genvar gl = 0; gl <= L; gl++) begin : g_lvl
    localparam int M = P >> gl;
    logic [M*W-1:0] v;
    if (gl == 0) begin : g_leaf
      assign v = (M*W)'(terms_i);
    end else begin : g_add
      // Pairwise sum of the previous level.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v <= '0;
        end else begin
          for (int j = 0; j < M; j++)
            v[j*W +: W] <=
              g_lvl[gl-1].v[(2*j)*W +: W] +
              g_lvl[gl-1].v[(2*j+1)*W +: W];
        end
      end
    end
  end

  assign sum_o = g_lvl[L].v;

endmodule

// File: rtl/dsp_route_mixer.sv
// dsp_route_mixer: per-sink source select and
// saturating DAC mixer, shadowed config over sys bus.
module dsp_route_mixer
  import dsp_route_pkg::*;
#(
  parameter int DW     = 14,
  parameter int N_SRC  = 16,
  parameter int N_SINK = 16,
  parameter int N_DAC  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SRC*DW-1:0] src_i,
  output logic [N_SINK*DW-1:0] sink_o,
  output logic [N_DAC*DW-1:0] dac_o,
  output logic [N_DAC-1:0]    sat_o,
  input  logic [15:0]         sys_addr,
  input  logic [31:0]         sys_wdata,
  input  logic                sys_wen,
  input  logic                sys_ren,
  output logic [31:0]         sys_rdata,
  output logic                sys_ack,
  output logic                sys_err
);

  localparam int SEL_W = clog2(N_SRC + 1);
  localparam int L     = clog2(N_SRC);
  localparam int AW    = DW + L;

  localparam logic [SEL_W-1:0] SEL_NONE =
    SEL_W'(sel_none(N_SRC));
  localparam logic signed [AW-1:0] MAXV =
    {{(L+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(L+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [6:0] NSINK7 = 7'(N_SINK);
  localparam logic [6:0] NSRC7  = 7'(N_SRC);
  localparam logic [6:0] NDAC7  = 7'(N_DAC);

  logic [SEL_W-1:0]   sh_sel   [N_SINK];
  logic [SEL_W-1:0]   act_sel  [N_SINK];
  logic [N_DAC-1:0]   sh_mask  [N_SRC];
  logic [N_DAC-1:0]   act_mask [N_SRC];
  logic [SHIFT_W-1:0] sh_shift [N_SRC];
  logic [SHIFT_W-1:0] act_shift[N_SRC];

  logic [N_DAC-1:0] flags;
  logic [15:0]      cnt [N_DAC];

  logic [5:0] idx, cidx;
  logic hit_sink, hit_src, hit_commit;
  logic hit_flags, hit_cnt, mapped;
  logic acc, wr;
  logic [31:0] rd_val;
  logic unused_wdata;

  logic [N_SINK*DW-1:0] sink_d;
  logic [N_SRC*AW-1:0]  term_d [N_DAC];
  logic [N_SRC*AW-1:0]  term_q [N_DAC];
  logic signed [AW-1:0] sum    [N_DAC];
  logic [N_DAC*DW-1:0]  dac_d;
  logic [N_DAC-1:0]     sat_d;

  assign unused_wdata = ^sys_wdata;
  assign acc  = sys_wen | sys_ren;
  assign wr   = sys_wen;
  assign idx  = sys_addr[7:2];
  assign cidx = idx - SAT_CNT_BASE[7:2];

  // Address decode; misaligned or out-of-range is unmapped.
  always_comb begin
    hit_sink   = 1'b0;
    hit_src    = 1'b0;
    hit_cnt    = 1'b0;
    hit_commit = sys_addr == COMMIT;
    hit_flags  = sys_addr == SAT_FLAGS;
    if (sys_addr[1:0] == 2'b00) begin
      hit_sink = sys_addr[15:8] == SINK_BASE[15:8]
        && {1'b0, idx} < NSINK7;
      hit_src = sys_addr[15:8] == SRC_BASE[15:8]
        && {1'b0, idx} < NSRC7;
      hit_cnt = sys_addr[15:8] == SAT_CNT_BASE[15:8]
        && idx >= SAT_CNT_BASE[7:2]
        && {1'b0, cidx} < NDAC7;
    end
    mapped = hit_sink | hit_src | hit_commit
      | hit_flags | hit_cnt;
  end

  // Readback mux; shadows are returned, not actives.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < N_SINK; k++)
      if (hit_sink && idx == 6'(k))
        rd_val = 32'(sh_sel[k]);
    for (int k = 0; k < N_SRC; k++)
      if (hit_src && idx == 6'(k)) begin
        rd_val[N_DAC-1:0] = sh_mask[k];
        rd_val[SHIFT_LSB +: SHIFT_W] = sh_shift[k];
      end
    if (hit_flags)
      rd_val = 32'(flags);
    for (int d = 0; d < N_DAC; d++)
      if (hit_cnt && cidx == 6'(d))
        rd_val = 32'(cnt[d]);
  end

  // Shadow writes and atomic commit to actives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_SINK; k++) begin
        sh_sel[k]  <= SEL_NONE;
        act_sel[k] <= SEL_NONE;
      end
      for (int k = 0; k < N_SRC; k++) begin
        sh_mask[k]   <= '0;
        act_mask[k]  <= '0;
        sh_shift[k]  <= '0;
        act_shift[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_SINK; k++)
        if (wr && hit_sink && idx == 6'(k))
          sh_sel[k] <= sys_wdata[SEL_W-1:0];
      for (int k = 0; k < N_SRC; k++)
        if (wr && hit_src && idx == 6'(k)) begin
          sh_mask[k]  <= sys_wdata[N_DAC-1:0];
          sh_shift[k] <= sys_wdata[SHIFT_LSB +: SHIFT_W];
        end
      if (wr && hit_commit) begin
        act_sel   <= sh_sel;
        act_mask  <= sh_mask;
        act_shift <= sh_shift;
      end
    end
  end

  // Sink routing; NONE or out-of-range selects give 0.
  always_comb begin
    sink_d = '0;
    for (int k = 0; k < N_SINK; k++)
      for (int s = 0; s < N_SRC; s++)
        if (act_sel[k] == SEL_W'(s))
          sink_d[k*DW +: DW] = src_i[s*DW +: DW];
  end

  // Per-DAC enabled, attenuated, sign-extended terms.
  always_comb begin
    for (int d = 0; d < N_DAC; d++)
      term_d[d] = '0;
    for (int k = 0; k < N_SRC; k++) begin
      logic signed [DW-1:0] sv;
      sv = $signed(src_i[k*DW +: DW]) >>> act_shift[k];
      for (int d = 0; d < N_DAC; d++)
        if (act_mask[k][d])
          term_d[d][k*AW +: AW] = {{L{sv[DW-1]}}, sv};
    end
  end

  for (genvar gd = 0; gd < N_DAC; gd++) begin : g_dac
    dsp_adder_tree #(
      .W (AW),
      .N (N_SRC)
    ) u_tree (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .terms_i (term_q[gd]),
      .sum_o   (sum[gd])
    );
  end

  // Clamp the tree result to the DW-bit range.
  always_comb begin
    dac_d = '0;
    sat_d = '0;
    for (int d = 0; d < N_DAC; d++) begin
      dac_d[d*DW +: DW] = sum[d][DW-1:0];
      if (sum[d] > MAXV) begin
        sat_d[d] = 1'b1;
        dac_d[d*DW +: DW] = MAXV[DW-1:0];
      end else if (sum[d] < MINV) begin
        sat_d[d] = 1'b1;
        dac_d[d*DW +: DW] = MINV[DW-1:0];
      end
    end
  end

  // Datapath registers: sinks, terms, clamped outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sink_o <= '0;
      dac_o  <= '0;
      sat_o  <= '0;
      for (int d = 0; d < N_DAC; d++)
        term_q[d] <= '0;
    end else begin
      sink_o <= sink_d;
      dac_o  <= dac_d;
      sat_o  <= sat_d;
      term_q <= term_d;
    end
  end

  // Sticky flags and counters; a new saturation beats a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags <= '0;
      for (int d = 0; d < N_DAC; d++)
        cnt[d] <= '0;
    end else begin
      if (wr && hit_flags)
        flags <= (flags & ~sys_wdata[N_DAC-1:0]) | sat_d;
      else
        flags <= flags | sat_d;
      for (int d = 0; d < N_DAC; d++) begin
        if (wr && hit_cnt && cidx == 6'(d))
          cnt[d] <= {15'd0, sat_d[d]};
        else if (sat_d[d] && cnt[d] != 16'hFFFF)
          cnt[d] <= cnt[d] + 16'd1;
      end
    end
  end

  // Bus response, one cycle after each access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= acc;
      sys_err   <= acc & ~mapped;
      sys_rdata <= (sys_ren && mapped) ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_dsp_route_mixer.sv
// tb_dsp_route_mixer: directed and randomized checks
// of routing, mixing, saturation and the bus.
module tb_dsp_route_mixer;

  localparam int DW = 14;
  localparam int NS = 16;
  localparam int NK = 16;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NS*DW-1:0] src;
  logic [NK*DW-1:0] sink;
  logic [ND*DW-1:0] dac;
  logic [ND-1:0]    sat;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  logic wen, ren, ack, err;

  int total = 0;
  int bad = 0;

  int srcv [NS];
  int a_sel[NK], s_sel[NK];
  int a_msk[NS], s_msk[NS];
  int a_sh [NS], s_sh [NS];

  typedef struct packed {
    logic [ND*DW-1:0] dac;
    logic [ND-1:0]    sat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  dsp_route_mixer #(
    .DW(DW), .N_SRC(NS), .N_SINK(NK), .N_DAC(ND)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .src_i     (src),
    .sink_o    (sink),
    .dac_o     (dac),
    .sat_o     (sat),
    .sys_addr  (addr),
    .sys_wdata (wdata),
    .sys_wen   (wen),
    .sys_ren   (ren),
    .sys_rdata (rdata),
    .sys_ack   (ack),
    .sys_err   (err)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] s14(input int v);
    return v[DW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++)
      src[k*DW +: DW] = srcv[k][DW-1:0];
  endtask

  // Mixer result straight from the arithmetic rules.
  function automatic exp_t model();
    exp_t e;
    e = '0;
    for (int d = 0; d < ND; d++) begin
      int s, v;
      s = 0;
      for (int k = 0; k < NS; k++)
        if (a_msk[k][d]) s += srcv[k] >>> a_sh[k];
      v = s;
      if (s > 8191) begin v = 8191; e.sat[d] = 1'b1; end
      if (s < -8192) begin v = -8192; e.sat[d] = 1'b1; end
      e.dac[d*DW +: DW] = v[DW-1:0];
    end
    return e;
  endfunction

  function automatic logic [NK*DW-1:0] sink_model();
    logic [NK*DW-1:0] r;
    r = '0;
    for (int k = 0; k < NK; k++)
      if (a_sel[k] < NS)
        r[k*DW +: DW] = srcv[a_sel[k]][DW-1:0];
    return r;
  endfunction

  task automatic bus_wr(input logic [15:0] a,
                        input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    step();
    wen = 1'b0;
    chk("wr_ack", ack, 1);
  endtask

  task automatic bus_rd(input logic [15:0] a,
                        output logic [31:0] d);
    addr = a; ren = 1'b1;
    step();
    ren = 1'b0;
    chk("rd_ack", ack, 1);
    d = rdata;
  endtask

  task automatic set_sel(input int k, input int v);
    bus_wr(16'(4 * k), v);
    s_sel[k] = v & 31;
  endtask

  task automatic set_cfg(input int k, input int v);
    bus_wr(16'(256 + 4 * k), v);
    s_msk[k] = v & 3;
    s_sh[k]  = (v >> 8) & 3;
  endtask

  task automatic commit();
    bus_wr(16'h200, 32'h0);
    a_sel = s_sel;
    a_msk = s_msk;
    a_sh  = s_sh;
  endtask

  task automatic rstep(input int amp);
    logic [NK*DW-1:0] es;
    exp_t e;
    for (int k = 0; k < NS; k++)
      srcv[k] = int'($urandom_range(0, 2*amp - 1)) - amp;
    drive();
    es = sink_model();
    q.push_back(model());
    step();
    chk("rnd_sink", sink, es);
    if (q.size() == 6) begin
      e = q.pop_front();
      chk("rnd_dac", dac, e.dac);
      chk("rnd_sat", sat, e.sat);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int nsat, first;
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    addr = '0; wdata = '0; src = '0;
    for (int k = 0; k < NS; k++) begin
      srcv[k] = 0; a_msk[k] = 0; s_msk[k] = 0;
      a_sh[k] = 0; s_sh[k] = 0;
    end
    for (int k = 0; k < NK; k++) begin
      a_sel[k] = 16; s_sel[k] = 16;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state
    chk("rst_sink", sink, 0);
    chk("rst_dac", dac, 0);
    chk("rst_sat", sat, 0);
    repeat (3) begin
      step();
      chk("idle_ack", ack, 0);
    end
    bus_rd(16'h000, rd);
    chk("rst_sel0", rd, 16);

    // 2: shadow has no effect until commit
    for (int k = 0; k < NS; k++)
      srcv[k] = int'($urandom_range(1, 8000)) - 4000;
    drive();
    set_sel(3, 5);
    repeat (20) begin
      step();
      chk("pre_commit_sink3", sink[3*DW +: DW], 0);
    end
    commit();
    chk("commit_edge_sink3", sink[3*DW +: DW], 0);
    step();
    chk("post_commit_sink3", sink[3*DW +: DW], s14(srcv[5]));
    step();
    chk("post_commit_sink3b", sink[3*DW +: DW], s14(srcv[5]));

    // 3: two-source mix and attenuation
    for (int k = 0; k < NS; k++) srcv[k] = 0;
    srcv[0] = 1000; srcv[1] = -300;
    drive();
    set_cfg(0, 32'h1);
    set_cfg(1, 32'h1);
    commit();
    repeat (5) step();
    chk("mix_not_early", dac[0 +: DW], 0);
    step();
    chk("mix_dac0", dac[0 +: DW], s14(700));
    chk("mix_dac1", dac[DW +: DW], 0);
    set_cfg(0, 32'h201);
    commit();
    repeat (6) step();
    chk("atten_dac0", dac[0 +: DW], s14(-50));

    // 4: positive and negative saturation on DAC1
    for (int k = 0; k < NS; k++) srcv[k] = 0;
    drive();
    for (int k = 0; k < 3; k++) set_cfg(k, 32'h2);
    commit();
    repeat (8) step();
    bus_wr(16'h20C, 32'h0);
    bus_wr(16'h204, 32'h3);
    for (int k = 0; k < 3; k++) srcv[k] = 8191;
    drive();
    nsat = 0; first = -1;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) begin
        for (int k = 0; k < 3; k++) srcv[k] = 0;
        drive();
      end
      step();
      if (sat[1]) begin
        nsat++;
        if (first < 0) first = i;
        chk("sat_hi_dac1", dac[DW +: DW], s14(8191));
      end
      chk("sat_dac0_quiet", sat[0], 0);
    end
    chk("sat_cycles", nsat, 10);
    chk("sat_latency", first, 5);
    bus_rd(16'h20C, rd);
    chk("sat_cnt1", rd, 10);
    bus_rd(16'h204, rd);
    chk("sat_flags", rd, 2);
    for (int k = 0; k < NS; k++) srcv[k] = -8192;
    drive();
    repeat (7) step();
    chk("sat_lo_dac1", dac[DW +: DW], s14(-8192));
    chk("sat_lo_bits", sat, 2'b10);

    // 5: clear collisions while still saturating
    bus_wr(16'h204, 32'h2);
    bus_rd(16'h204, rd);
    chk("w1c_vs_set", rd, 2);
    bus_wr(16'h20C, 32'h0);
    bus_rd(16'h20C, rd);
    chk("clr_vs_inc", rd, 1);
    for (int k = 0; k < NS; k++) srcv[k] = 0;
    drive();
    repeat (8) step();
    bus_wr(16'h204, 32'h2);
    bus_rd(16'h204, rd);
    chk("w1c_clear", rd, 0);

    // back-to-back accesses are each acked
    addr = 16'h204; wdata = 0; wen = 1'b1;
    step();
    chk("b2b_ack1", ack, 1);
    step();
    chk("b2b_ack2", ack, 1);
    wen = 1'b0;
    step();
    chk("b2b_ack_end", ack, 0);

    // randomized configs against the model
    for (int r = 0; r < 4; r++) begin
      int kk;
      for (int k = 0; k < NK; k++) set_sel(k, int'($urandom));
      for (int k = 0; k < NS; k++) set_cfg(k, int'($urandom));
      kk = int'($urandom_range(0, NS - 1));
      bus_rd(16'(256 + 4 * kk), rd);
      chk("shadow_rb", rd, s_msk[kk] | (s_sh[kk] << 8));
      commit();
      q.delete();
      repeat (40) rstep(r[0] ? 8192 : 1500);
    end

    // 6: unmapped accesses
    bus_rd(16'h300, rd);
    chk("unmap_err", err, 1);
    chk("unmap_rdata", rd, 0);
    step();
    chk("unmap_ack_pulse", ack, 0);
    chk("unmap_err_pulse", err, 0);
    bus_rd(16'h040, rd);
    chk("sink_idx_err", err, 1);
    bus_rd(16'h210, rd);
    chk("cnt_idx_err", err, 1);
    bus_rd(16'h03C, rd);
    chk("mapped_no_err", err, 0);

    // asynchronous reset mid-stream
    set_sel(0, 1);
    set_cfg(1, 32'h3);
    commit();
    for (int k = 0; k < NS; k++) srcv[k] = 0;
    srcv[1] = 1234;
    drive();
    repeat (8) step();
    chk("pre_rst_sink", sink, sink_model());
    chk("pre_rst_dac", dac, model().dac);
    rst = 1'b1;
    #1;
    chk("async_rst_sink", sink, 0);
    chk("async_rst_dac", dac, 0);
    chk("async_rst_sat", sat, 0);
    step();
    rst = 1'b0;
    bus_rd(16'h004, rd);
    chk("rst_sel1", rd, 16);
    bus_rd(16'h104, rd);
    chk("rst_cfg1", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
